psum_accum_writeback: RTL
=========================

// Module: psum_accum_writeback
// PURPOSE
//  Parametrised multi-core partial-sum accumulator and output-BRAM writer for the convolution array.
//  Takes NUM_CORES psum lanes per entry from the convolution cores and accumulates them over
//  no_channel channel-group passes of no_entry entries each.
//  On the last pass it requantises each lane (shift, optional ReLU, saturate) and writes one packed word per entry.
// PARAMETERS
//  NUM_CORES  4     number of parallel convolution cores (psum lanes)
//  PSUM_W     8     signed psum width per lane, in and out
//  ACC_W      16    signed accumulator width per lane
//  MAX_ENTRY  1024  accumulator buffer depth (entries per lane)
//  ADDR_W     32    output BRAM byte-address width
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  en           in   1                  global enable; low freezes all state
//  start        in   1                  1-cycle pulse; latches configuration (IDLE only)
//  no_channel   in   11                 number of channel-group passes
//  no_entry     in   16                 entries per pass
//  base_addr    in   ADDR_W             output byte address of entry 0
//  shift        in   4                  arithmetic right shift applied before saturation
//  relu_en      in   1                  clamp negative results to 0
//  in_valid     in   1                  in_psum valid this cycle
//  in_ready     out  1                  block accepts in_psum this cycle
//  in_psum      in   NUM_CORES*PSUM_W   lane k = bits [k*PSUM_W +: PSUM_W], signed
//  out_we       out  1                  output BRAM write strobe
//  out_addr     out  ADDR_W             output BRAM byte address
//  out_din      out  NUM_CORES*PSUM_W   packed requantised lanes, same lane order as in_psum
//  channel_end  out  1                  1-cycle pulse after the last entry of each pass
//  done         out  1                  1-cycle pulse when the job completes
//  busy         out  1                  high in any state other than IDLE
//  cfg_err      out  1                  1-cycle pulse on an illegal start configuration
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=IDLE, counters=0; every output 0. Buffer contents are don't-care.
//  - en=0: nothing advances; in_ready=0, out_we=0, channel_end=0, done=0; all registers hold.
//  - FSM states: IDLE, ACCUM, DONE.
//  - IDLE -> ACCUM on start with 1<=no_channel, 1<=no_entry<=MAX_ENTRY.
//    Config is latched; entry counter e=0, pass counter p=0.
//  - IDLE on start with no_channel=0, no_entry=0 or no_entry>MAX_ENTRY:
//    cfg_err pulses the next cycle; FSM stays in IDLE.
//  - start outside IDLE is ignored.
//  - ACCUM: in_ready=en. Transfer = in_valid & in_ready. Per transfer, for each lane:
//    p==0: buf[e] = sext(psum); else buf[e] = sat_ACC_W(buf[e] + sext(psum)).
//    The addition saturates to the signed ACC_W range and never wraps.
//  - Last pass (p==no_channel-1): per transfer, the sum is requantised:
//    r = sum>>>shift; if relu_en and r<0 then r=0; saturate r to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
//    One cycle after the transfer: out_we=1, out_addr=base_addr+4*e, out_din=packed r.
//    The buffer write may be skipped on this pass.
//  - Latency: transfer on cycle t -> write on cycle t+1. Back-to-back transfers give back-to-back writes.
//  - e wraps to 0 after no_entry-1, then p increments; channel_end pulses on the cycle after that transfer.
//  - After the final transfer of the last pass: ACCUM -> DONE. done=1 for one cycle, coincident with
//    the last out_we, then -> IDLE.
//  - no_channel=1: single pass; every entry is written directly, with no accumulation.
//  - out_addr/out_din hold their last value when out_we=0.
//  - Reset mid-job aborts immediately with no further writes; the next start runs a fresh job.
// TESTING
//  1 NUM_CORES=4, no_channel=4, no_entry=9, base=0x100, shift=0, all psum=1
//    -> 9 writes of 0x04040404 to 0x100..0x120 step 4; channel_end x4; done x1.
//  2 psum lanes=0x7F, 4 passes, shift=0 -> 0x7F7F7F7F (saturated);
//    shift=2 -> 508>>>2=127 -> 0x7F7F7F7F; shift=3 -> 0x3F3F3F3F.
//  3 lane0 psum=-3 (0xFD), 4 passes: relu_en=0 -> lane0=0xF4; relu_en=1 -> lane0=0x00.
//  4 en=0 for 5 cycles mid-pass 2 with in_valid=1 -> no transfers, no strobes; final data equals test 1.
//  5 start with no_entry=0 -> cfg_err pulse, busy=0, no writes;
//    start while busy -> ignored, job unaffected.
//  6 rst_n low during pass 2 -> all outputs 0 at once; a new start (no_channel=1) completes correctly.

Source files
------------

// File: rtl/psum_accum_writeback.sv
// Multi-core partial-sum accumulator: sums NUM_CORES psum lanes over no_channel passes of
// no_entry entries, then requantises each lane and writes one packed word per entry.
module psum_accum_writeback #(
    parameter int NUM_CORES = 4,
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_ENTRY = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          start,
    input  logic [10:0]                   no_channel,
    input  logic [15:0]                   no_entry,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [3:0]                    shift,
    input  logic                          relu_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CORES*PSUM_W-1:0]   in_psum,
    output logic                          out_we,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [NUM_CORES*PSUM_W-1:0]   out_din,
    output logic                          channel_end,
    output logic                          done,
    output logic                          busy,
    output logic                          cfg_err
);
    localparam int          E_W         = (MAX_ENTRY > 1) ? $clog2(MAX_ENTRY) : 1;
    localparam logic [16:0] MAX_ENTRY_W = 17'(MAX_ENTRY);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [10:0]       cfg_channel;
    logic [15:0]       cfg_entry;
    logic [ADDR_W-1:0] cfg_base;
    logic [3:0]        cfg_shift;
    logic              cfg_relu;
    logic [15:0]       e_cnt;
    logic [10:0]       p_cnt;
    logic              we_q;
    logic              ch_end_q;
    logic              err_q;

    logic [NUM_CORES*ACC_W-1:0]  acc_mem [MAX_ENTRY];
    logic [NUM_CORES*ACC_W-1:0]  acc_rd;
    logic [NUM_CORES*ACC_W-1:0]  acc_nxt;
    logic [NUM_CORES*PSUM_W-1:0] q_nxt;
    logic [ACC_W-1:0]            lane_x;
    logic [ACC_W-1:0]            lane_s;
    logic                        xfer;
    logic                        last_entry;
    logic                        last_pass;
    logic                        cfg_ok;

    // Signed add clamped to the ACC_W range; overflow shows as disagreeing top two bits.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [PSUM_W-1:0] requant(input logic [ACC_W-1:0] a,
                                                  input logic [3:0]       sh,
                                                  input logic             relu);
        logic [ACC_W-1:0] r;
        r = ACC_W'($signed(a) >>> sh);
        if (relu && r[ACC_W-1])
            r = '0;
        if (r[ACC_W-1:PSUM_W-1] == {(ACC_W-PSUM_W+1){r[ACC_W-1]}})
            return r[PSUM_W-1:0];
        return r[ACC_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    endfunction

    assign in_ready   = en && (state == S_ACCUM);
    assign xfer       = in_valid && in_ready;
    assign last_entry = (e_cnt == cfg_entry - 16'd1);
    assign last_pass  = (p_cnt == cfg_channel - 11'd1);
    assign cfg_ok     = (no_channel != 11'd0) && (no_entry != 16'd0) &&
                        ({1'b0, no_entry} <= MAX_ENTRY_W);
    assign acc_rd     = acc_mem[e_cnt[E_W-1:0]];

    always_comb begin
        acc_nxt = '0;
        q_nxt   = '0;
        lane_x  = '0;
        lane_s  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            lane_x = {{(ACC_W-PSUM_W){in_psum[k*PSUM_W+PSUM_W-1]}}, in_psum[k*PSUM_W +: PSUM_W]};
            lane_s = (p_cnt == '0) ? lane_x : sat_add(acc_rd[k*ACC_W +: ACC_W], lane_x);
            acc_nxt[k*ACC_W +: ACC_W]  = lane_s;
            q_nxt[k*PSUM_W +: PSUM_W] = requant(lane_s, cfg_shift, cfg_relu);
        end
    end

    // NOTE: the accumulator buffer has no reset; pass 0 overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (xfer && !last_pass)
            acc_mem[e_cnt[E_W-1:0]] <= acc_nxt;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cfg_channel <= '0;
            cfg_entry   <= '0;
            cfg_base    <= '0;
            cfg_shift   <= '0;
            cfg_relu    <= 1'b0;
            e_cnt       <= '0;
            p_cnt       <= '0;
            we_q        <= 1'b0;
            ch_end_q    <= 1'b0;
            err_q       <= 1'b0;
            out_addr    <= '0;
            out_din     <= '0;
        end else if (en) begin
            we_q     <= 1'b0;
            ch_end_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && cfg_ok) begin
                        cfg_channel <= no_channel;
                        cfg_entry   <= no_entry;
                        cfg_base    <= base_addr;
                        cfg_shift   <= shift;
                        cfg_relu    <= relu_en;
                        e_cnt       <= '0;
                        p_cnt       <= '0;
                        state       <= S_ACCUM;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        if (last_pass) begin
                            we_q     <= 1'b1;
                            out_addr <= cfg_base + ADDR_W'({e_cnt, 2'b00});
                            out_din  <= q_nxt;
                        end
                        if (last_entry) begin
                            e_cnt    <= '0;
                            ch_end_q <= 1'b1;
                            if (last_pass)
                                state <= S_DONE;
                            else
                                p_cnt <= p_cnt + 11'd1;
                        end else begin
                            e_cnt <= e_cnt + 16'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pulse flags survive an en=0 stall and are presented once en returns.
    assign out_we      = we_q && en;
    assign channel_end = ch_end_q && en;
    assign cfg_err     = err_q && en;
    assign done        = en && (state == S_DONE);
    assign busy        = (state != S_IDLE);

endmodule
